// File: rtl/or1200_loader_pkg.sv
// Shared definitions for the or1200 RAM boot loader: FSM encoding,
// frame geometry and the default frame-start byte.
package or1200_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_RELEASE,
    ST_ERROR
  } ld_state_e;

  localparam int         HDR_BYTES      = 4;
  localparam int         BYTES_PER_WORD = 4;
  localparam logic [7:0] DEFAULT_MAGIC  = 8'hA5;

endpackage

// File: rtl/or1200_loader_word_asm.sv
// Big-endian word assembler: shifts bytes in MSB first and flags the
// byte that completes a 32-bit word (combinational, same cycle as strobe).
module or1200_loader_word_asm
  import or1200_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  byte_i,
  input  logic        strobe_i,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  lane_q, lane_d;

  assign word_o      = word_q;
  assign word_full_o = strobe_i & (lane_q == 2'(BYTES_PER_WORD - 1));

  // Next-state: clear restarts the lane count, strobe shifts a byte in.
  always_comb begin
    word_d = word_q;
    lane_d = lane_q;
    if (clear_i) begin
      lane_d = 2'd0;
    end else if (strobe_i) begin
      word_d = {word_q[23:0], byte_i};
      lane_d = lane_q + 2'd1;
    end
  end

  // Shift register and lane counter; reset drops any partial word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q <= '0;
      lane_q <= '0;
    end else begin
      word_q <= word_d;
      lane_q <= lane_d;
    end
  end

endmodule

// File: rtl/or1200_ram_loader.sv
// Boot loader for the or1200 external RAM port. Parses a framed byte
// stream (MAGIC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, payload), writes one
// word per WRITE cycle while holding the CPU stalled, then releases it.
// Optional checksum byte and sticky error: define OR1200_RAM_LOADER_CSUM_EN.
module or1200_ram_loader
  import or1200_loader_pkg::*;
#(
  parameter int         ADDR_W      = 16,
  parameter logic [7:0] MAGIC       = DEFAULT_MAGIC,
  parameter int         RELEASE_DLY = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              cpu_stall_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int REL_W = $clog2(RELEASE_DLY + 1);

`ifdef OR1200_RAM_LOADER_CSUM_EN
  localparam ld_state_e END_ST = ST_CSUM;
`else
  localparam ld_state_e END_ST = ST_RELEASE;
`endif

  ld_state_e         state_q, state_d;
  logic [23:0]       hdr_q, hdr_d;
  logic [1:0]        hcnt_q, hcnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [16:0]       idx_q, idx_d;     // 17 bits: end compare never wraps
  logic [REL_W-1:0]  rel_q, rel_d;
  logic              stall_q, stall_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] ahold_q, ahold_d;
  logic [31:0]       dhold_q, dhold_d;
`ifdef OR1200_RAM_LOADER_CSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              err_q, err_d;
`endif

  logic              acc;
  logic [31:0]       asm_word;
  logic              asm_full;
  logic [ADDR_W-1:0] wr_addr;

  // Ready is withheld during reset so every output reads 0 while rst_i is high.
  assign byte_ready_o = ~rst_i & (state_q != ST_WRITE) & (state_q != ST_RELEASE);
  assign acc          = byte_valid_i & byte_ready_o;
  assign wr_addr      = base_q + ADDR_W'(idx_q);

  assign ram_we_o    = (state_q == ST_WRITE);
  assign ram_addr_o  = ram_we_o ? wr_addr  : ahold_q;
  assign ram_data_o  = ram_we_o ? asm_word : dhold_q;
  assign cpu_stall_o = stall_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
`ifdef OR1200_RAM_LOADER_CSUM_EN
  assign err_o       = err_q;
`else
  assign err_o       = 1'b0;
`endif

  or1200_loader_word_asm u_word_asm (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .byte_i      (byte_i),
    .strobe_i    (acc & (state_q == ST_DATA)),
    .clear_i     ((state_q == ST_IDLE) | (state_q == ST_ERROR)),
    .word_o      (asm_word),
    .word_full_o (asm_full)
  );

  // Frame FSM: next state, header/count bookkeeping, release timer.
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    hcnt_d  = hcnt_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rel_d   = rel_q;
    stall_d = stall_q;
    done_d  = 1'b0;
    ahold_d = ahold_q;
    dhold_d = dhold_q;
`ifdef OR1200_RAM_LOADER_CSUM_EN
    csum_d  = csum_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (acc && byte_i == MAGIC) begin
          state_d = ST_HDR;
          stall_d = 1'b1;
          hcnt_d  = 2'd0;
          idx_d   = '0;
`ifdef OR1200_RAM_LOADER_CSUM_EN
          csum_d  = 8'd0;
`endif
        end
      end
      ST_HDR: begin
        if (acc) begin
          hdr_d  = {hdr_q[15:0], byte_i};
          hcnt_d = hcnt_q + 2'd1;
`ifdef OR1200_RAM_LOADER_CSUM_EN
          csum_d = csum_q ^ byte_i;
`endif
          if (hcnt_q == 2'(HDR_BYTES - 1)) begin
            base_d  = ADDR_W'(hdr_q[23:8]);
            cnt_d   = {hdr_q[7:0], byte_i};
            state_d = (cnt_d == 16'd0) ? END_ST : ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (acc) begin
`ifdef OR1200_RAM_LOADER_CSUM_EN
          csum_d = csum_q ^ byte_i;
`endif
          if (asm_full) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        ahold_d = wr_addr;
        dhold_d = asm_word;
        idx_d   = idx_q + 17'd1;
        state_d = (idx_d == {1'b0, cnt_q}) ? END_ST : ST_DATA;
      end
`ifdef OR1200_RAM_LOADER_CSUM_EN
      ST_CSUM: begin
        if (acc) begin
          if (byte_i == csum_q) begin
            state_d = ST_RELEASE;
          end else begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      ST_ERROR: begin
        // Stall stays asserted; only a fresh MAGIC restarts the load.
        if (acc && byte_i == MAGIC) begin
          state_d = ST_HDR;
          err_d   = 1'b0;
          hcnt_d  = 2'd0;
          idx_d   = '0;
          csum_d  = 8'd0;
        end
      end
`endif
      ST_RELEASE: begin
        if (rel_q <= REL_W'(1)) begin
          state_d = ST_IDLE;
          stall_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          rel_d = rel_q - REL_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Timer loads on entry; done lands RELEASE_DLY cycles after the last
    // write (or after the header of an empty frame / the checksum byte).
    if (state_d == ST_RELEASE && state_q != ST_RELEASE)
      rel_d = REL_W'(RELEASE_DLY - 1);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      hdr_q   <= '0;
      hcnt_q  <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      rel_q   <= '0;
      stall_q <= 1'b0;
      done_q  <= 1'b0;
      ahold_q <= '0;
      dhold_q <= '0;
`ifdef OR1200_RAM_LOADER_CSUM_EN
      csum_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      hcnt_q  <= hcnt_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rel_q   <= rel_d;
      stall_q <= stall_d;
      done_q  <= done_d;
      ahold_q <= ahold_d;
      dhold_q <= dhold_d;
`ifdef OR1200_RAM_LOADER_CSUM_EN
      csum_q  <= csum_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule
